// File: rtl/tnn_packer_pkg.sv
// Shared types and constants for the TNN feature packer.
package tnn_packer_pkg;

    typedef logic [1:0] qfeat_t;

    typedef enum logic {
        COLLECT,
        DISCARD
    } state_t;

    localparam int unsigned N_FEAT   = 4;
    localparam logic [1:0]  LAST_IDX = 2'(N_FEAT - 1);

    localparam logic [1:0] CFG_SEL_T0 = 2'd0;
    localparam logic [1:0] CFG_SEL_T1 = 2'd1;
    localparam logic [1:0] CFG_SEL_T2 = 2'd2;

endpackage

// File: rtl/tnn_quantizer.sv
// Combinational 2-bit quantizer: highest threshold met wins.
module tnn_quantizer
    import tnn_packer_pkg::*;
#(
    parameter int unsigned FEAT_W = 8
) (
    input  logic [FEAT_W-1:0] x,
    input  logic [FEAT_W-1:0] t0,
    input  logic [FEAT_W-1:0] t1,
    input  logic [FEAT_W-1:0] t2,
    output qfeat_t            q
);

    always_comb begin
        q = 2'd0;
        if (x >= t2)      q = 2'd3;
        else if (x >= t1) q = 2'd2;
        else if (x >= t0) q = 2'd1;
    end

endmodule

// File: rtl/tnn_feature_packer.sv
// Quantizes a raw feature stream and packs four codes per vector with framing checks.
// Runtime-programmable thresholds when TNN_PACKER_THRESH_PROG_EN is defined.
module tnn_feature_packer
    import tnn_packer_pkg::*;
#(
    parameter int unsigned       FEAT_W = 8,
    parameter logic [FEAT_W-1:0] T0     = FEAT_W'(64),
    parameter logic [FEAT_W-1:0] T1     = FEAT_W'(128),
    parameter logic [FEAT_W-1:0] T2     = FEAT_W'(192)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FEAT_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_a,
    output logic [1:0]        out_b,
    output logic [1:0]        out_c,
    output logic [1:0]        out_d,
    output logic              out_err,
`ifdef TNN_PACKER_THRESH_PROG_EN
    output logic              err_pulse,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [FEAT_W-1:0] cfg_data
`else
    output logic              err_pulse
`endif
);

    state_t            state, state_next;
    logic [1:0]        cnt;
    qfeat_t            col_a, col_b, col_c;
    qfeat_t            q;
    logic              accept;
    logic [FEAT_W-1:0] th0, th1, th2;

`ifdef TNN_PACKER_THRESH_PROG_EN
    // A write lands at the clock edge, so an accept in the same cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            th0 <= T0;
            th1 <= T1;
            th2 <= T2;
        end else if (cfg_we) begin
            case (cfg_sel)
                CFG_SEL_T0: th0 <= cfg_data;
                CFG_SEL_T1: th1 <= cfg_data;
                CFG_SEL_T2: th2 <= cfg_data;
                default: ;
            endcase
        end
    end
`else
    assign th0 = T0;
    assign th1 = T1;
    assign th2 = T2;
`endif

    tnn_quantizer #(.FEAT_W(FEAT_W)) u_quant (
        .x  (in_data),
        .t0 (th0),
        .t1 (th1),
        .t2 (th2),
        .q  (q)
    );

    // Only the 4th feature needs the output register free; drain and load may coincide.
    assign in_ready = (cnt != LAST_IDX) || (state == DISCARD) || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                COLLECT: if (cnt == LAST_IDX && !in_last) state_next = DISCARD;
                DISCARD: if (in_last) state_next = COLLECT;
                default: state_next = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            col_a     <= '0;
            col_b     <= '0;
            col_c     <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_d     <= '0;
            out_err   <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept && state == COLLECT) begin
                if (cnt == LAST_IDX) begin
                    out_valid <= 1'b1;
                    out_a     <= col_a;
                    out_b     <= col_b;
                    out_c     <= col_c;
                    out_d     <= q;
                    out_err   <= !in_last;
                    cnt       <= '0;
                end else if (in_last) begin
                    err_pulse <= 1'b1;
                    cnt       <= '0;
                end else begin
                    case (cnt)
                        2'd0:    col_a <= q;
                        2'd1:    col_b <= q;
                        default: col_c <= q;
                    endcase
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Self-checking bench for tnn_feature_packer: queue-based reference model plus directed vectors.
// Covers the TNN_PACKER_THRESH_PROG_EN build when that macro is defined.
module tb_tnn_feature_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_a, out_b, out_c, out_d;
    logic       out_err;
    logic       err_pulse;
`ifdef TNN_PACKER_THRESH_PROG_EN
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_sel = '0;
    logic [7:0] cfg_data = '0;
`endif

    int total = 0;
    int bad   = 0;

    tnn_feature_packer #(.FEAT_W(8), .T0(8'd64), .T1(8'd128), .T2(8'd192)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_err   (out_err),
`ifdef TNN_PACKER_THRESH_PROG_EN
        .err_pulse (err_pulse),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data)
`else
        .err_pulse (err_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample kept as a queue of codes, vector emitted when four are held.
    int unsigned th[3];
    logic [1:0]  qq[$];
    bit          disc, mv, merr, mp;
    logic [7:0]  mvec;
    bit          rdy;
    logic [1:0]  qm;

    function automatic logic [1:0] quant(input int unsigned x);
        if (x >= th[2]) return 2'd3;
        if (x >= th[1]) return 2'd2;
        if (x >= th[0]) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit model_ready();
        return disc || (qq.size() != 3) || !mv || out_ready;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mv = 0; merr = 0; mp = 0; disc = 0; mvec = '0;
            qq.delete();
            th[0] = 64; th[1] = 128; th[2] = 192;
        end else begin
            rdy = model_ready();
            mp  = 0;
            if (mv && out_ready) mv = 0;
            if (in_valid && rdy) begin
                qm = quant(in_data);
                if (disc) begin
                    if (in_last) disc = 0;
                end else begin
                    qq.push_back(qm);
                    if (qq.size() == 4) begin
                        mvec = {qq[0], qq[1], qq[2], qq[3]};
                        mv   = 1;
                        merr = !in_last;
                        disc = !in_last;
                        qq.delete();
                    end else if (in_last) begin
                        mp = 1;
                        qq.delete();
                    end
                end
            end
`ifdef TNN_PACKER_THRESH_PROG_EN
            if (cfg_we && cfg_sel < 3) th[cfg_sel] = cfg_data;
`endif
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, model_ready());
        chk("out_valid", out_valid, mv);
        chk("err_pulse", err_pulse, mp);
        if (mv) begin
            chk("out_vec", {out_a, out_b, out_c, out_d}, mvec);
            chk("out_err", out_err, merr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one feature and return just after the edge that accepts it.
    task automatic send(input logic [7:0] x, input logic last);
        int k;
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) chk("ready_timeout", 0, 1);
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_vec", {out_a, out_b, out_c, out_d}, 0);
        chk("rst_err", out_err, 0);
        chk("rst_pulse", err_pulse, 0);
        rst = 1'b0;

        // Basic packing, one code of each value.
        out_ready = 1'b1;
        send(8'd10, 0); send(8'd64, 0); send(8'd150, 0); send(8'd255, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_vec", {out_a, out_b, out_c, out_d}, 8'b00_01_10_11);
        chk("t1_err", out_err, 0);
        idle();
        step();
        chk("t1_drained", out_valid, 0);

        // Backpressure: second sample stalls on its 4th feature.
        out_ready = 1'b0;
        send(8'd0, 0); send(8'd70, 0); send(8'd130, 0); send(8'd200, 1);
        send(8'd200, 0); send(8'd130, 0); send(8'd70, 0);
        in_valid = 1'b1; in_data = 8'd0; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_ready", in_ready, 0);
            chk("t2_hold_vec", {out_a, out_b, out_c, out_d}, 8'b00_01_10_11);
            chk("t2_hold_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("t2_release_ready", in_ready, 1);
        step();
        chk("t2_b2b_valid", out_valid, 1);
        chk("t2_b2b_vec", {out_a, out_b, out_c, out_d}, 8'b11_10_01_00);
        idle();
        step();
        chk("t2_done", out_valid, 0);

        // Short sample: dropped with a pulse, next sample clean.
        send(8'd100, 0); send(8'd100, 1);
        chk("t3_pulse", err_pulse, 1);
        chk("t3_no_vec", out_valid, 0);
        send(8'd255, 0);
        chk("t3_pulse_gone", err_pulse, 0);
        send(8'd192, 0); send(8'd191, 0); send(8'd63, 1);
        chk("t3_vec", {out_a, out_b, out_c, out_d}, 8'b11_11_10_00);
        chk("t3_err", out_err, 0);

        // Long sample: first four flagged, tail discarded.
        send(8'd0, 0); send(8'd64, 0); send(8'd128, 0); send(8'd192, 0);
        chk("t4_vec", {out_a, out_b, out_c, out_d}, 8'b00_01_10_11);
        chk("t4_err", out_err, 1);
        send(8'd5, 0); send(8'd6, 1);
        chk("t4_no_pulse", err_pulse, 0);
        send(8'd63, 0); send(8'd127, 0); send(8'd191, 0); send(8'd255, 1);
        chk("t4_clean_vec", {out_a, out_b, out_c, out_d}, 8'b00_01_10_11);
        chk("t4_clean_err", out_err, 0);
        idle();
        step();

        // Reset with a vector pending and a partial sample.
        out_ready = 1'b0;
        send(8'd200, 0); send(8'd200, 0); send(8'd200, 0); send(8'd200, 1);
        send(8'd1, 0); send(8'd2, 0);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_vec", {out_a, out_b, out_c, out_d}, 0);
        chk("t5_pulse", err_pulse, 0);
        out_ready = 1'b1;
        send(8'd255, 0); send(8'd0, 0); send(8'd255, 0); send(8'd0, 1);
        chk("t5_fresh_vec", {out_a, out_b, out_c, out_d}, 8'b11_00_11_00);
        idle();
        step();

`ifdef TNN_PACKER_THRESH_PROG_EN
        // Threshold programming; a write alongside an accept uses the old value.
        for (int i = 0; i < 4; i++) send(8'd110, i == 3);
        chk("t6_before", {out_a, out_b, out_c, out_d}, 8'b01_01_01_01);
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 8'd100;
        send(8'd110, 0);
        cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) send(8'd110, i == 2);
        chk("t6_after", {out_a, out_b, out_c, out_d}, 8'b01_10_10_10);
        idle();
        step();
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
